uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_fifo.sv | 62 ++++++
 rtl/uart_tx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Holds the FSM state encoding, parity-mode codes and a frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop
    } tx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Bits on the line for one frame: start + data + optional parity + stop.
    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input int unsigned parity,
                                               input int unsigned stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous single-clock FIFO with extra-MSB pointers for full/empty detection.
// Push while full and pop while empty are ignored; a simultaneous push and pop both happen.
module uart_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [Width-1:0]         din,
    output logic [Width-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   level
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bits means the write pointer is a full lap ahead.
    assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign level = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[AddrW-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (AddrW + 1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AddrW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO: frames are start, LSB-first data, optional parity, stop bits.
// Frames run back to back while words are queued; txd is driven from a register.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          din,
    input  logic                          enable,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          txd,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);

    localparam int unsigned TimerW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitCntW = 4;

    tx_state_e              state_q, state_d;
    logic [TimerW-1:0]      timer_q, timer_d;
    logic [BitCntW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   txd_q, txd_d;
    logic                   done_q, done_d;
    logic                   overflow_q, overflow_d;

    logic                   fifo_pop;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_dout;
    logic                   par_bit;
    logic                   tick;

    uart_fifo #(
        .Width (DATA_BITS),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (enable),
        .pop   (fifo_pop),
        .din   (din),
        .dout  (fifo_dout),
        .full  (full),
        .empty (fifo_empty),
        .level (level)
    );

    assign tick     = (timer_q == TimerW'(CLKS_PER_BIT - 1));
    assign txd      = txd_q;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign overflow = overflow_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + TimerW'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        done_d     = 1'b0;
        fifo_pop   = 1'b0;
        overflow_d = overflow_q | (enable & full);
        par_bit    = ^fifo_dout;
        if (PARITY == PAR_ODD) begin
            par_bit = ~par_bit;
        end

        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_dout;
                    par_d     = par_bit;
                    bit_cnt_d = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (tick) begin
                    timer_d = '0;
                    if (bit_cnt_q == BitCntW'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? StPar : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            StPar: begin
                if (tick) begin
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    timer_d = '0;
                    if (bit_cnt_q == BitCntW'(STOP_BITS - 1)) begin
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        // Chain straight into the next start bit when a word is waiting.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = fifo_dout;
                            par_d    = par_bit;
                            state_d  = StStart;
                        end else begin
                            state_d  = StIdle;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end
            end
            default: begin
                timer_d = '0;
                state_d = StIdle;
            end
        endcase

        // Line level follows the state being entered, so txd changes on the same edge.
        unique case (state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shift_d[0];
            StPar:   txd_d = par_d;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations (8N1, 8E1, 8O1, 5N2) against a waveform-level model.
// The model queues accepted words and expands each popped word into its per-cycle line levels.
module tb_uart_tx_fifo;

    localparam int unsigned Clks   = 4;
    localparam int unsigned NumCfg = 4;
    localparam int unsigned MaxWait = 30000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40) begin
                $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
            end
        end
    endtask

    for (genvar g = 0; g < NumCfg; g++) begin : g_cfg
        localparam int unsigned Db    = (g == 3) ? 5 : 8;
        localparam int unsigned Par   = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
        localparam int unsigned Stop  = (g == 3) ? 2 : 1;
        localparam int unsigned Depth = (g == 0) ? 8 : ((g == 1) ? 2 : 4);
        localparam int unsigned LvlW  = $clog2(Depth) + 1;

        logic            rst    = 1'b1;
        logic            enable = 1'b0;
        logic [Db-1:0]   din    = '0;
        logic            full, txd, busy, done, overflow;
        logic [LvlW-1:0] level;
        logic            fin    = 1'b0;

        bit          line[$];
        int unsigned mq[$];
        bit          exp_ovf  = 1'b0;
        bit          exp_done = 1'b0;

        uart_tx_fifo #(
            .CLKS_PER_BIT (Clks),
            .DATA_BITS    (Db),
            .PARITY       (Par),
            .STOP_BITS    (Stop),
            .FIFO_DEPTH   (Depth)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .din      (din),
            .enable   (enable),
            .full     (full),
            .level    (level),
            .txd      (txd),
            .busy     (busy),
            .done     (done),
            .overflow (overflow)
        );

        function automatic void push_bit(input bit b);
            for (int k = 0; k < Clks; k++) line.push_back(b);
        endfunction

        function automatic void load_frame(input int unsigned w);
            int unsigned ones;
            bit          b;
            ones = 0;
            push_bit(1'b0);
            for (int i = 0; i < Db; i++) begin
                b = bit'((w >> i) & 1);
                ones += b;
                push_bit(b);
            end
            if (Par == 2) push_bit(bit'(ones % 2));
            if (Par == 1) push_bit(bit'(1 - (ones % 2)));
            for (int s = 0; s < Stop; s++) push_bit(1'b1);
        endfunction

        // Apply inputs at the falling edge, advance the model on the rising edge, check next fall.
        task automatic cyc(input bit r, input bit e, input int unsigned d);
            bit was_full;
            rst    = r;
            enable = e;
            din    = d[Db-1:0];
            @(posedge clk);
            if (r) begin
                line.delete();
                mq.delete();
                exp_ovf  = 1'b0;
                exp_done = 1'b0;
            end else begin
                was_full = (mq.size() == Depth);
                exp_done = 1'b0;
                if (line.size() > 0) begin
                    void'(line.pop_front());
                    exp_done = (line.size() == 0);
                end
                if (line.size() == 0 && mq.size() > 0) load_frame(mq.pop_front());
                if (e) begin
                    if (was_full) exp_ovf = 1'b1;
                    else mq.push_back(d & ((1 << Db) - 1));
                end
            end
            @(negedge clk);
            check_eq($sformatf("cfg%0d txd", g), 32'(txd),
                     32'((line.size() > 0) ? line[0] : 1'b1));
            check_eq($sformatf("cfg%0d busy", g), 32'(busy), 32'(line.size() > 0));
            check_eq($sformatf("cfg%0d done", g), 32'(done), 32'(exp_done));
            check_eq($sformatf("cfg%0d level", g), 32'(level), 32'(mq.size()));
            check_eq($sformatf("cfg%0d full", g), 32'(full), 32'(mq.size() == Depth));
            check_eq($sformatf("cfg%0d overflow", g), 32'(overflow), 32'(exp_ovf));
        endtask

        task automatic idle(input int unsigned n);
            for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0);
        endtask

        initial begin : p_stim
            int unsigned dens;
            @(negedge clk);
            repeat (3) cyc(1'b1, 1'b1, 32'hFF);
            cyc(1'b0, 1'b1, 32'hF1);
            idle(60);
            cyc(1'b0, 1'b1, 32'h15);
            cyc(1'b0, 1'b1, 32'h0A);
            idle(120);
            for (int i = 0; i < Depth + 2; i++) cyc(1'b0, 1'b1, i);
            idle((Depth + 2) * 60);
            // Abort a frame mid-flight with more words queued behind it.
            cyc(1'b0, 1'b1, 32'hF1);
            cyc(1'b0, 1'b1, 32'h33);
            cyc(1'b0, 1'b1, 32'h5C);
            idle(12);
            cyc(1'b1, 1'b0, 0);
            idle(20);
            cyc(1'b0, 1'b1, 32'hF1);
            idle(20);
            cyc(1'b0, 1'b1, 32'h02);
            idle(100);
            for (int i = 0; i < 2000; i++) begin
                dens = (i < 500) ? 4 : ((i < 1000) ? 20 : ((i < 1500) ? 60 : 100));
                cyc($urandom_range(0, 599) == 0, $urandom_range(0, 99) < dens, $urandom);
            end
            idle(700);
            fin = 1'b1;
        end
    end

    initial begin : p_main
        int unsigned waited;
        waited = 0;
        while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) &&
               waited < MaxWait) begin
            @(posedge clk);
            waited++;
        end
        if (waited >= MaxWait) check_eq("timeout", 32'd0, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
